// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer/count controller and write/read arbiter for a 16 x 8
// single-port FIFO storage array. One storage command per cycle. When the
// writer and the reader both qualify in the same cycle, the side that did not
// win the previous conflict gets the slot.
//
// Ports
//   clk, reset      rising-edge clock, synchronous active-high reset
//   wr_req / wr_ack push request / push accepted this cycle (combinational)
//   rd_req / rd_ack pop request / pop accepted this cycle (combinational)
//   rd_valid        registered; storage data_out holds the popped byte
//   flush           synchronous clear of pointers, count, rd_valid, errors
//   full, empty, almost_full, count   occupancy status
//   overflow_err, underflow_err       sticky request-while-full/empty flags
//   st_ptr_in, st_ptr_out             storage indices {1'b0, ptr}
//   st_en_write, st_en_read           storage command lines
module fifo_ctrl #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned AF_LEVEL = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_req,
  output logic       wr_ack,
  input  logic       rd_req,
  output logic       rd_ack,
  output logic       rd_valid,
  input  logic       flush,
  output logic       full,
  output logic       empty,
  output logic       almost_full,
  output logic [4:0] count,
  output logic       overflow_err,
  output logic       underflow_err,
  output logic [4:0] st_ptr_in,
  output logic [4:0] st_ptr_out,
  output logic       st_en_write,
  output logic       st_en_read
);

  localparam int unsigned PTR_W = 4;
  localparam int unsigned CNT_W = 5;

  typedef enum logic {
    GRANT_WRITE = 1'b0,
    GRANT_READ  = 1'b1
  } grant_e;

  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  grant_e           last_q, last_d;
  logic             rd_valid_q, rd_valid_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             grant_w, grant_r;
  logic             can_wr, can_rd;

  // Occupancy flags decoded from the registered count.
  assign full        = (count_q == CNT_W'(DEPTH));
  assign empty       = (count_q == CNT_W'(0));
  assign almost_full = (count_q >= CNT_W'(AF_LEVEL));

  assign count         = count_q;
  assign rd_valid      = rd_valid_q;
  assign overflow_err  = ovf_q;
  assign underflow_err = unf_q;
  assign st_ptr_in     = {1'b0, wptr_q};
  assign st_ptr_out    = {1'b0, rptr_q};

  // Arbitration and next-state.
  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    last_d     = last_q;
    rd_valid_d = 1'b0;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    grant_w    = 1'b0;
    grant_r    = 1'b0;
    can_wr     = wr_req & ~full;
    can_rd     = rd_req & ~empty;

    if (reset) begin
      // Register block applies reset values; only keep the command idle here.
      grant_w = 1'b0;
      grant_r = 1'b0;
    end else if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else begin
      if (wr_req && full)  ovf_d = 1'b1;
      if (rd_req && empty) unf_d = 1'b1;

      if (can_wr && can_rd) begin
        // Conflict: the side that lost last time wins now.
        if (last_q == GRANT_READ) begin
          grant_w = 1'b1;
          last_d  = GRANT_WRITE;
        end else begin
          grant_r = 1'b1;
          last_d  = GRANT_READ;
        end
      end else begin
        grant_w = can_wr;
        grant_r = can_rd;
      end

      if (grant_w) begin
        wptr_d  = wptr_q + PTR_W'(1);
        count_d = count_q + CNT_W'(1);
      end
      if (grant_r) begin
        rptr_d     = rptr_q + PTR_W'(1);
        count_d    = count_q - CNT_W'(1);
        rd_valid_d = 1'b1;
      end
    end
  end

  // The array decodes {en_write, en_read}: 2'b01 = write, 2'b10 = read.
  assign wr_ack      = grant_w;
  assign rd_ack      = grant_r;
  assign st_en_write = grant_r;
  assign st_en_read  = grant_w;

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      last_q     <= GRANT_READ;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      last_q     <= last_d;
      rd_valid_q <= rd_valid_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: self-checking bench for fifo_ctrl. Contains a behavioural
// model of the storage array and a queue-based FIFO reference model.
module tb_fifo_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_req = 1'b0;
  logic       rd_req = 1'b0;
  logic       flush = 1'b0;
  logic       wr_ack, rd_ack, rd_valid, full, empty, almost_full;
  logic [4:0] count, st_ptr_in, st_ptr_out;
  logic       overflow_err, underflow_err, st_en_write, st_en_read;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic [7:0] mem [16];

  fifo_ctrl #(.DEPTH(16), .AF_LEVEL(12)) dut (
    .clk(clk), .reset(reset), .wr_req(wr_req), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_ack(rd_ack), .rd_valid(rd_valid), .flush(flush),
    .full(full), .empty(empty), .almost_full(almost_full), .count(count),
    .overflow_err(overflow_err), .underflow_err(underflow_err),
    .st_ptr_in(st_ptr_in), .st_ptr_out(st_ptr_out),
    .st_en_write(st_en_write), .st_en_read(st_en_read)
  );

  always #5 clk = ~clk;

  // Storage array: {en_write,en_read} 01 = write, 10 = read (1-cycle latency).
  always @(posedge clk) begin
    if (reset) begin
      data_out <= 8'h00;
      for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
    end else if ({st_en_write, st_en_read} == 2'b01) begin
      mem[st_ptr_in[3:0]] <= data_in;
    end else if ({st_en_write, st_en_read} == 2'b10) begin
      data_out <= mem[st_ptr_out[3:0]];
    end
  end

  // Reference model state.
  logic [7:0] q[$];
  int         n_push = 0, n_pop = 0;
  bit         m_last_w = 1'b0, m_ovf = 1'b0, m_unf = 1'b0, m_rdv = 1'b0;
  logic [7:0] m_data = 8'h00;
  bit         e_gw, e_gr, e_conf;
  logic [1:0] e_cmd;
  int         n_chk = 0, n_fail = 0;

  // Drive one cycle's inputs mid-cycle and predict this cycle's grants.
  task automatic step(input bit rs, input bit w, input bit r, input bit f,
                      input logic [7:0] d);
    int cnt;
    bit cw, cr;
    @(negedge clk);
    reset = rs; wr_req = w; rd_req = r; flush = f; data_in = d;
    #1;
    cnt = q.size();
    cw = w && (cnt < 16);
    cr = r && (cnt > 0);
    e_gw = 1'b0; e_gr = 1'b0; e_conf = 1'b0;
    if (!rs && !f) begin
      if (cw && cr) begin
        e_conf = 1'b1;
        if (m_last_w) e_gr = 1'b1; else e_gw = 1'b1;
      end else begin
        e_gw = cw; e_gr = cr;
      end
    end
    e_cmd = e_gw ? 2'b01 : (e_gr ? 2'b10 : 2'b00);
  endtask

  // Take the clock edge and update the reference model.
  task automatic advance();
    int cnt;
    @(posedge clk);
    cnt = q.size();
    if (reset || flush) begin
      q.delete(); n_push = 0; n_pop = 0;
      m_rdv = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
      if (reset) m_last_w = 1'b0;
    end else begin
      if (wr_req && cnt == 16) m_ovf = 1'b1;
      if (rd_req && cnt == 0)  m_unf = 1'b1;
      if (e_gw) begin q.push_back(data_in); n_push++; end
      m_rdv = e_gr;
      if (e_gr) begin m_data = q.pop_front(); n_pop++; end
      if (e_conf) m_last_w = e_gw;
    end
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 8'h00); advance();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      step(1, 1, 1, 0, 8'h33);
      n_chk++; if ({wr_ack, rd_ack} !== 2'b00) begin n_fail++; $display("FAIL reset_acks: got %b want 00", {wr_ack, rd_ack}); end
      n_chk++; if ({st_en_write, st_en_read} !== 2'b00) begin n_fail++; $display("FAIL reset_cmd: got %b want 00", {st_en_write, st_en_read}); end
      advance();
    end
    step(0, 0, 0, 0, 8'h00);
    n_chk++; if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0) begin n_fail++; $display("FAIL reset_state: count %0d empty %b full %b want 0 1 0", count, empty, full); end
    n_chk++; if ({rd_valid, overflow_err, underflow_err} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {rd_valid, overflow_err, underflow_err}); end
    n_chk++; if (st_ptr_in !== 5'd0 || st_ptr_out !== 5'd0) begin n_fail++; $display("FAIL reset_ptrs: got %0d/%0d want 0/0", st_ptr_in, st_ptr_out); end
    advance();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 0, 0, 8'(8'h10 + i));
      n_chk++; if (wr_ack !== 1'b1 || {st_en_write, st_en_read} !== 2'b01) begin n_fail++; $display("FAIL fill_ack[%0d]: ack %b cmd %b want 1 01", i, wr_ack, {st_en_write, st_en_read}); end
      n_chk++; if (st_ptr_in !== 5'(i)) begin n_fail++; $display("FAIL fill_ptr[%0d]: got %0d want %0d", i, st_ptr_in, i); end
      n_chk++; if (count !== 5'(i) || almost_full !== (i >= 12)) begin n_fail++; $display("FAIL fill_count[%0d]: count %0d af %b want %0d %b", i, count, almost_full, i, i >= 12); end
      advance();
    end
    step(0, 0, 0, 0, 8'h00);
    n_chk++; if (count !== 5'd16 || full !== 1'b1 || almost_full !== 1'b1) begin n_fail++; $display("FAIL fill_full: count %0d full %b af %b want 16 1 1", count, full, almost_full); end
    advance();
  endtask

  task automatic test_overflow_drain();
    step(0, 1, 0, 0, 8'hEE);
    n_chk++; if (wr_ack !== 1'b0 || {st_en_write, st_en_read} !== 2'b00) begin n_fail++; $display("FAIL ovf_ack: ack %b cmd %b want 0 00", wr_ack, {st_en_write, st_en_read}); end
    advance();
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 1, 0, 8'h00);
      n_chk++; if (overflow_err !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky[%0d]: got %b want 1", i, overflow_err); end
      n_chk++; if (rd_ack !== 1'b1 || st_ptr_out !== 5'(i)) begin n_fail++; $display("FAIL drain_ack[%0d]: ack %b ptr %0d want 1 %0d", i, rd_ack, st_ptr_out, i); end
      if (i == 0) begin
        n_chk++; if (count !== 5'd16) begin n_fail++; $display("FAIL ovf_count: got %0d want 16", count); end
      end else begin
        n_chk++; if (rd_valid !== 1'b1 || data_out !== 8'(8'h10 + i - 1)) begin n_fail++; $display("FAIL drain_data[%0d]: valid %b data %h want 1 %h", i - 1, rd_valid, data_out, 8'(8'h10 + i - 1)); end
      end
      advance();
    end
    step(0, 0, 0, 0, 8'h00);
    n_chk++; if (rd_valid !== 1'b1 || data_out !== 8'h1F || empty !== 1'b1) begin n_fail++; $display("FAIL drain_last: valid %b data %h empty %b want 1 1f 1", rd_valid, data_out, empty); end
    advance();
    step(0, 0, 0, 0, 8'h00);
    n_chk++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL drain_idle_valid: got %b want 0", rd_valid); end
    advance();
  endtask

  task automatic test_alternate();
    do_reset();
    for (int i = 0; i < 4; i++) begin step(0, 1, 0, 0, 8'($urandom)); advance(); end
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 1, 0, 8'($urandom));
      n_chk++; if (wr_ack !== (i % 2 == 0) || rd_ack !== (i % 2 == 1)) begin n_fail++; $display("FAIL alt_grant[%0d]: w %b r %b want %b %b", i, wr_ack, rd_ack, i % 2 == 0, i % 2 == 1); end
      n_chk++; if ({st_en_write, st_en_read} === 2'b11 || {st_en_write, st_en_read} !== e_cmd) begin n_fail++; $display("FAIL alt_cmd[%0d]: got %b want %b", i, {st_en_write, st_en_read}, e_cmd); end
      n_chk++; if (count !== 5'(4 + (i % 2))) begin n_fail++; $display("FAIL alt_count[%0d]: got %0d want %0d", i, count, 4 + (i % 2)); end
      advance();
    end
  endtask

  task automatic test_wrap();
    step(0, 0, 0, 1, 8'h00); advance();
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 10; i++) begin
        step(0, 1, 0, 0, (b == 1) ? 8'(8'hA0 + i) : 8'($urandom));
        n_chk++; if (wr_ack !== 1'b1 || st_ptr_in !== 5'((b * 10 + i) % 16)) begin n_fail++; $display("FAIL wrap_push[%0d.%0d]: ack %b ptr %0d want 1 %0d", b, i, wr_ack, st_ptr_in, (b * 10 + i) % 16); end
        advance();
      end
      for (int i = 0; i <= 10; i++) begin
        step(0, (i < 10), 0, 0, 8'h00);
        rd_req = (i < 10);
        #1;
        if (i < 10) begin e_gr = 1'b1; e_gw = 1'b0; e_cmd = 2'b10; end else begin e_gr = 1'b0; e_cmd = 2'b00; end
        wr_req = 1'b0;
        if (i > 0) begin
          n_chk++; if (rd_valid !== 1'b1 || data_out !== m_data) begin n_fail++; $display("FAIL wrap_data[%0d.%0d]: valid %b data %h want 1 %h", b, i - 1, rd_valid, data_out, m_data); end
          if (b == 1) begin
            n_chk++; if (data_out !== 8'(8'hA0 + i - 1)) begin n_fail++; $display("FAIL wrap_a0[%0d]: got %h want %h", i - 1, data_out, 8'(8'hA0 + i - 1)); end
          end
        end
        advance();
      end
    end
  endtask

  task automatic test_empty_flush();
    step(0, 0, 1, 0, 8'h00);
    n_chk++; if (rd_ack !== 1'b0 || {st_en_write, st_en_read} !== 2'b00) begin n_fail++; $display("FAIL unf_ack: ack %b cmd %b want 0 00", rd_ack, {st_en_write, st_en_read}); end
    advance();
    step(0, 1, 0, 0, 8'h77);
    n_chk++; if (underflow_err !== 1'b1 || rd_valid !== 1'b0) begin n_fail++; $display("FAIL unf_flag: unf %b valid %b want 1 0", underflow_err, rd_valid); end
    advance();
    step(0, 1, 0, 1, 8'h55);
    n_chk++; if (wr_ack !== 1'b0 || {st_en_write, st_en_read} !== 2'b00 || count !== 5'd1) begin n_fail++; $display("FAIL flush_ack: ack %b cmd %b count %0d want 0 00 1", wr_ack, {st_en_write, st_en_read}, count); end
    advance();
    step(0, 0, 0, 0, 8'h00);
    n_chk++; if (count !== 5'd0 || {overflow_err, underflow_err} !== 2'b00 || st_ptr_in !== 5'd0) begin n_fail++; $display("FAIL flush_clear: count %0d errs %b ptr %0d want 0 00 0", count, {overflow_err, underflow_err}, st_ptr_in); end
    advance();
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    for (int i = 0; i < 4; i++) begin step(0, 1, 0, 0, 8'(i)); advance(); end
    step(0, 1, 1, 0, 8'h44); advance();
    step(0, 0, 1, 0, 8'h00);
    n_chk++; if (rd_ack !== 1'b1 || count !== 5'd5) begin n_fail++; $display("FAIL mid_read_grant: ack %b count %0d want 1 5", rd_ack, count); end
    advance();
    step(1, 1, 1, 0, 8'h00);
    n_chk++; if ({wr_ack, rd_ack, st_en_write, st_en_read} !== 4'b0000) begin n_fail++; $display("FAIL mid_reset_acks: got %b want 0000", {wr_ack, rd_ack, st_en_write, st_en_read}); end
    n_chk++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL mid_reset_prev_valid: got %b want 1", rd_valid); end
    advance();
    step(0, 0, 0, 0, 8'h00);
    n_chk++; if (rd_valid !== 1'b0 || count !== 5'd0) begin n_fail++; $display("FAIL mid_reset_after: valid %b count %0d want 0 0", rd_valid, count); end
    advance();
    step(0, 1, 0, 0, 8'h99); advance();
    step(0, 1, 1, 0, 8'h9A);
    n_chk++; if (wr_ack !== 1'b1 || rd_ack !== 1'b0) begin n_fail++; $display("FAIL post_reset_conflict: w %b r %b want 1 0", wr_ack, rd_ack); end
    advance();
  endtask

  task automatic test_random();
    bit rs, w, r, f;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rs = ($urandom_range(99) == 0);
      f  = ($urandom_range(49) == 0);
      // Drift between fill-heavy and drain-heavy phases to hit both ends.
      w  = ($urandom_range(99) < (((i / 80) % 2 == 0) ? 75 : 25));
      r  = ($urandom_range(99) < (((i / 80) % 2 == 0) ? 25 : 75));
      step(rs, w, r, f, 8'($urandom));
      n_chk++; if (wr_ack !== e_gw || rd_ack !== e_gr || {st_en_write, st_en_read} !== e_cmd) begin n_fail++; $display("FAIL rand_grant[%0d]: w %b r %b cmd %b want %b %b %b", i, wr_ack, rd_ack, {st_en_write, st_en_read}, e_gw, e_gr, e_cmd); end
      n_chk++; if (count !== 5'(q.size()) || full !== (q.size() == 16) || empty !== (q.size() == 0) || almost_full !== (q.size() >= 12)) begin n_fail++; $display("FAIL rand_count[%0d]: count %0d f/e/af %b%b%b want %0d", i, count, full, empty, almost_full, q.size()); end
      n_chk++; if (st_ptr_in !== 5'(n_push % 16) || st_ptr_out !== 5'(n_pop % 16)) begin n_fail++; $display("FAIL rand_ptr[%0d]: in %0d out %0d want %0d %0d", i, st_ptr_in, st_ptr_out, n_push % 16, n_pop % 16); end
      n_chk++; if (overflow_err !== m_ovf || underflow_err !== m_unf) begin n_fail++; $display("FAIL rand_err[%0d]: ovf %b unf %b want %b %b", i, overflow_err, underflow_err, m_ovf, m_unf); end
      n_chk++; if (rd_valid !== m_rdv || (m_rdv && data_out !== m_data)) begin n_fail++; $display("FAIL rand_data[%0d]: valid %b data %h want %b %h", i, rd_valid, data_out, m_rdv, m_data); end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow_drain();
    test_alternate();
    test_wrap();
    test_empty_flush();
    test_reset_mid_read();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
